rob_commit: RTL and testbench

In-order retirement stage paired with the `rename` block. It accepts renamed instructions (`rinstr_t`) from rename's output register and holds them in a circular reorder buffer. It marks entries complete from write-back and retires them in program order. On retirement it drives the `p_commit` interface that rename consumes. It also tracks the single in-flight branch and squashes younger entries on a mispredict, in step with rename's snapshot restore.

---
 rtl/rob_commit.sv | 192 +++++++++++++++++++
 tb/tb_rob_commit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// Reorder buffer for the rename stage. It allocates renamed instructions in order, marks them
// complete from write-back, and retires them in order onto the p_commit port.
module rob_commit #(
    parameter int DEPTH   = 16,
    parameter int P_IDX_W = 6,
    parameter int TAG_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic [P_IDX_W+2:0] rinstr_i,     // rinstr_t {valid, rd}
    input  logic               is_branch_i,
    output logic [TAG_W-1:0]   rob_tag_o,
    output logic               rob_full_o,
    input  logic               wb_valid_i,
    input  logic [TAG_W-1:0]   wb_tag_i,
    input  logic [1:0]         br_result_i,  // br_result_t {valid, hit}
    output logic [P_IDX_W+1:0] p_commit_o,   // p_reg_t {valid, idx, ready}
    output logic               flush_o
);

    typedef struct packed {
        logic               valid;
        logic [P_IDX_W-1:0] idx;
        logic               ready;
    } p_reg_t;

    typedef struct packed {
        logic   valid;
        p_reg_t rd;
    } rinstr_t;

    typedef struct packed {
        logic valid;
        logic hit;
    } br_result_t;

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    rinstr_t    w_rinstr;
    br_result_t w_br;
    logic       w_unused_rd_ready;

    assign w_rinstr          = rinstr_i;
    assign w_br              = br_result_i;
    assign w_unused_rd_ready = w_rinstr.rd.ready;

    logic [TAG_W-1:0]   r_head;
    logic [TAG_W-1:0]   r_tail;
    logic [TAG_W:0]     r_count;
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_done;
    logic [DEPTH-1:0]   r_is_br;
    logic [DEPTH-1:0]   r_rd_vld;
    logic [P_IDX_W-1:0] r_rd_idx [DEPTH];
    logic               r_br_active;
    logic [TAG_W-1:0]   r_br_tag;
    p_reg_t             r_p_commit;
    logic               r_flush;

    logic               w_full;
    logic               w_resolve;
    logic               w_squash;
    logic               w_alloc;
    logic               w_commit;
    logic               w_wb_ok;
    logic               w_new_br;
    logic [TAG_W-1:0]   w_br_off;
    logic [DEPTH-1:0]   w_younger;
    logic [DEPTH-1:0]   w_valid_nxt;
    logic [DEPTH-1:0]   w_done_nxt;
    logic [DEPTH-1:0]   w_is_br_nxt;
    logic [TAG_W:0]     w_count_nxt;

    assign w_full    = (r_count == FULL_CNT);
    assign w_resolve = w_br.valid && r_br_active;
    assign w_squash  = w_resolve && !w_br.hit;
    assign w_alloc   = w_rinstr.valid && !w_full && !w_squash;
    assign w_commit  = r_valid[r_head] && r_done[r_head];
    assign w_br_off  = r_br_tag - r_head;
    // A branch resolving this cycle frees the slot, so a new branch may claim it at once.
    assign w_new_br  = w_alloc && is_branch_i && (!r_br_active || w_resolve);

    // Age is measured from head, so "younger than the branch" survives pointer wrap.
    always_comb begin
        logic [TAG_W-1:0] v_off;
        w_younger = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_off        = TAG_W'(i) - r_head;
            w_younger[i] = (v_off > w_br_off);
        end
    end

    assign w_wb_ok = wb_valid_i && r_valid[wb_tag_i] && !r_is_br[wb_tag_i]
                     && !(w_squash && w_younger[wb_tag_i]);

    // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        w_valid_nxt = r_valid;
        w_done_nxt  = r_done;
        w_is_br_nxt = r_is_br;
        if (w_commit) begin
            w_valid_nxt[r_head] = 1'b0;
        end
        if (w_squash) begin
            w_valid_nxt = w_valid_nxt & ~w_younger;
        end
        if (w_wb_ok) begin
            w_done_nxt[wb_tag_i] = 1'b1;
        end
        if (w_resolve) begin
            w_done_nxt[r_br_tag] = 1'b1;
        end
        if (w_alloc) begin
            w_valid_nxt[r_tail] = 1'b1;
            w_done_nxt[r_tail]  = 1'b0;
            w_is_br_nxt[r_tail] = is_branch_i;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_squash) begin
            w_count_nxt = {1'b0, w_br_off} + 1'b1 - (TAG_W+1)'(w_commit);
        end else begin
            w_count_nxt = r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_commit);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_valid     <= '0;
            r_done      <= '0;
            r_is_br     <= '0;
            r_br_active <= 1'b0;
            r_br_tag    <= '0;
            r_p_commit  <= '0;
            r_flush     <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_is_br <= w_is_br_nxt;
            r_count <= w_count_nxt;
            r_flush <= w_squash;

            if (w_commit) begin
                r_head <= r_head + 1'b1;
            end
            if (w_squash) begin
                r_tail <= r_br_tag + 1'b1;
            end else if (w_alloc) begin
                r_tail <= r_tail + 1'b1;
            end

            if (w_resolve) begin
                r_br_active <= 1'b0;
            end
            if (w_new_br) begin
                r_br_active <= 1'b1;
                r_br_tag    <= r_tail;
            end

            r_p_commit <= '0;
            if (w_commit && r_rd_vld[r_head] && (r_rd_idx[r_head] != '0)) begin
                r_p_commit.valid <= 1'b1;
                r_p_commit.idx   <= r_rd_idx[r_head];
                r_p_commit.ready <= 1'b1;
            end
        end
    end

    // NOTE: the destination payload is not reset; it is only read behind a valid bit that is.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_rd_vld[r_tail] <= w_rinstr.rd.valid;
            r_rd_idx[r_tail] <= w_rinstr.rd.idx;
        end
    end

    // Rename holds back a second branch until the first resolves.
    a_single_branch: assert property (@(posedge clk) disable iff (!rst_ni)
        !(w_alloc && is_branch_i && r_br_active && !w_resolve));

    assign rob_tag_o  = r_tail;
    assign rob_full_o = w_full;
    assign p_commit_o = r_p_commit;
    assign flush_o    = r_flush;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: each task drives one scenario and checks
// the outputs against hand-computed values.
module tb_rob_commit;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [8:0] rinstr_i = '0;
    logic       is_branch_i = 1'b0;
    logic [3:0] rob_tag_o;
    logic       rob_full_o;
    logic       wb_valid_i = 1'b0;
    logic [3:0] wb_tag_i = '0;
    logic [1:0] br_result_i = '0;
    logic [7:0] p_commit_o;
    logic       flush_o;

    int checks = 0;
    int failures = 0;

    rob_commit dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .rinstr_i    (rinstr_i),
        .is_branch_i (is_branch_i),
        .rob_tag_o   (rob_tag_o),
        .rob_full_o  (rob_full_o),
        .wb_valid_i  (wb_valid_i),
        .wb_tag_i    (wb_tag_i),
        .br_result_i (br_result_i),
        .p_commit_o  (p_commit_o),
        .flush_o     (flush_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] pc(input int idx);
        return {1'b1, 6'(idx), 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rinstr_i    = '0;
        is_branch_i = 1'b0;
        wb_valid_i  = 1'b0;
        wb_tag_i    = '0;
        br_result_i = '0;
    endtask

    task automatic set_alloc(input bit rdv, input int idx, input bit br);
        rinstr_i    = {1'b1, rdv, 6'(idx), 1'b0};
        is_branch_i = br;
    endtask

    task automatic alloc(input bit rdv, input int idx, input bit br);
        set_alloc(rdv, idx, br);
        tick();
        rinstr_i    = '0;
        is_branch_i = 1'b0;
    endtask

    task automatic set_wb(input int tag);
        wb_valid_i = 1'b1;
        wb_tag_i   = 4'(tag);
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // Branch at tag 5 with five older and four younger entries.
    task automatic setup_branch();
        do_reset();
        for (int i = 0; i < 5; i++) alloc(1'b1, 10 + i, 1'b0);
        alloc(1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) alloc(1'b1, 20 + i, 1'b0);
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 1'b0;
        tick();
        checks++; if (p_commit_o !== 8'h00) begin failures++; $display("FAIL reset_p_commit: got %h expected 00", p_commit_o); end
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL reset_flush: got %b expected 0", flush_o); end
        checks++; if (rob_full_o !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", rob_full_o); end
        checks++; if (rob_tag_o !== 4'd0) begin failures++; $display("FAIL reset_tag: got %0d expected 0", rob_tag_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic_commit();
        int         tags[3] = '{2, 0, 1};
        logic [7:0] exp[6];
        exp = '{8'h00, 8'h00, pc(32), pc(33), 8'h00, 8'h00};
        do_reset();
        alloc(1'b1, 32, 1'b0);
        alloc(1'b1, 33, 1'b0);
        alloc(1'b1, 0, 1'b0);
        checks++; if (rob_tag_o !== 4'd3) begin failures++; $display("FAIL basic_tag: got %0d expected 3", rob_tag_o); end
        for (int k = 0; k < 6; k++) begin
            if (k < 3) set_wb(tags[k]); else wb_valid_i = 1'b0;
            tick();
            checks++;
            if (p_commit_o !== exp[k]) begin
                failures++;
                $display("FAIL basic_commit[%0d]: got %h expected %h", k, p_commit_o, exp[k]);
            end
        end
        idle();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_alloc(1'b1, i + 1, 1'b0);
            tick();
            checks++;
            if (rob_full_o !== (i == 15)) begin
                failures++;
                $display("FAIL full_fill[%0d]: got %b expected %b", i, rob_full_o, (i == 15));
            end
        end
        checks++; if (rob_tag_o !== 4'd0) begin failures++; $display("FAIL full_tag_wrap: got %0d expected 0", rob_tag_o); end
        set_alloc(1'b1, 40, 1'b0);
        tick();
        idle();
        checks++; if (rob_tag_o !== 4'd0) begin failures++; $display("FAIL full_drop_tag: got %0d expected 0", rob_tag_o); end
        checks++; if (rob_full_o !== 1'b1) begin failures++; $display("FAIL full_drop_full: got %b expected 1", rob_full_o); end
        set_wb(0);
        tick();
        idle();
        // Commit and attempted allocation in the same cycle: allocation must still be refused.
        set_alloc(1'b1, 41, 1'b0);
        tick();
        idle();
        checks++; if (p_commit_o !== pc(1)) begin failures++; $display("FAIL full_commit: got %h expected %h", p_commit_o, pc(1)); end
        checks++; if (rob_tag_o !== 4'd0) begin failures++; $display("FAIL full_commit_tag: got %0d expected 0", rob_tag_o); end
        checks++; if (rob_full_o !== 1'b0) begin failures++; $display("FAIL full_commit_full: got %b expected 0", rob_full_o); end
        alloc(1'b1, 42, 1'b0);
        checks++; if (rob_tag_o !== 4'd1) begin failures++; $display("FAIL full_refill_tag: got %0d expected 1", rob_tag_o); end
        checks++; if (rob_full_o !== 1'b1) begin failures++; $display("FAIL full_refill_full: got %b expected 1", rob_full_o); end
    endtask

    task automatic test_squash();
        int         tags[6] = '{0, 1, 2, 3, 4, 6};
        logic [7:0] exp[9];
        exp = '{8'h00, pc(10), pc(11), pc(12), pc(13), pc(14), 8'h00, pc(40), 8'h00};
        setup_branch();
        checks++; if (rob_tag_o !== 4'd10) begin failures++; $display("FAIL squash_setup_tag: got %0d expected 10", rob_tag_o); end
        br_result_i = 2'b10;
        tick();
        br_result_i = '0;
        checks++; if (rob_tag_o !== 4'd6) begin failures++; $display("FAIL squash_tail: got %0d expected 6", rob_tag_o); end
        checks++; if (flush_o !== 1'b1) begin failures++; $display("FAIL squash_flush: got %b expected 1", flush_o); end
        alloc(1'b1, 40, 1'b0);
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL squash_flush_pulse: got %b expected 0", flush_o); end
        checks++; if (rob_tag_o !== 4'd7) begin failures++; $display("FAIL squash_realloc_tag: got %0d expected 7", rob_tag_o); end
        set_wb(8);
        tick();
        idle();
        for (int k = 0; k < 9; k++) begin
            if (k < 6) set_wb(tags[k]); else wb_valid_i = 1'b0;
            tick();
            checks++;
            if (p_commit_o !== exp[k]) begin
                failures++;
                $display("FAIL squash_commit[%0d]: got %h expected %h", k, p_commit_o, exp[k]);
            end
        end
        idle();
        // A stale squashed entry at tag 8 must not retire after the new tag 7.
        alloc(1'b1, 41, 1'b0);
        set_wb(7);
        tick();
        idle();
        tick();
        checks++; if (p_commit_o !== pc(41)) begin failures++; $display("FAIL squash_tag7: got %h expected %h", p_commit_o, pc(41)); end
        tick();
        checks++; if (p_commit_o !== 8'h00) begin failures++; $display("FAIL squash_stale8: got %h expected 00", p_commit_o); end
    endtask

    task automatic test_hit();
        int         tags[9] = '{0, 1, 2, 3, 4, 6, 7, 8, 9};
        logic [7:0] exp[12];
        exp = '{8'h00, pc(10), pc(11), pc(12), pc(13), pc(14), 8'h00,
                pc(20), pc(21), pc(22), pc(23), 8'h00};
        setup_branch();
        br_result_i = 2'b11;
        tick();
        br_result_i = '0;
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL hit_flush: got %b expected 0", flush_o); end
        checks++; if (rob_tag_o !== 4'd10) begin failures++; $display("FAIL hit_tail: got %0d expected 10", rob_tag_o); end
        for (int k = 0; k < 12; k++) begin
            if (k < 9) set_wb(tags[k]); else wb_valid_i = 1'b0;
            tick();
            checks++;
            if (p_commit_o !== exp[k]) begin
                failures++;
                $display("FAIL hit_commit[%0d]: got %h expected %h", k, p_commit_o, exp[k]);
            end
        end
        idle();
    endtask

    task automatic test_wrap_squash();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            set_alloc(1'b0, 0, 1'b0);
            if (i > 0) set_wb(i - 1); else wb_valid_i = 1'b0;
            tick();
        end
        idle();
        set_wb(13);
        tick();
        idle();
        repeat (3) tick();
        checks++; if (rob_tag_o !== 4'd14) begin failures++; $display("FAIL wrap_drain_tag: got %0d expected 14", rob_tag_o); end
        alloc(1'b1, 50, 1'b0);
        alloc(1'b1, 51, 1'b0);
        alloc(1'b1, 52, 1'b0);
        alloc(1'b0, 0, 1'b1);
        alloc(1'b1, 53, 1'b0);
        alloc(1'b1, 54, 1'b0);
        checks++; if (rob_tag_o !== 4'd4) begin failures++; $display("FAIL wrap_fill_tag: got %0d expected 4", rob_tag_o); end
        set_wb(14);
        tick();
        idle();
        br_result_i = 2'b10;
        tick();
        br_result_i = '0;
        checks++; if (p_commit_o !== pc(50)) begin failures++; $display("FAIL wrap_commit: got %h expected %h", p_commit_o, pc(50)); end
        checks++; if (flush_o !== 1'b1) begin failures++; $display("FAIL wrap_flush: got %b expected 1", flush_o); end
        checks++; if (rob_tag_o !== 4'd2) begin failures++; $display("FAIL wrap_tail: got %0d expected 2", rob_tag_o); end
        checks++; if (rob_full_o !== 1'b0) begin failures++; $display("FAIL wrap_full: got %b expected 0", rob_full_o); end
        // Three entries remain, so exactly 13 allocations fill the buffer.
        for (int i = 0; i < 13; i++) begin
            set_alloc(1'b1, 60 + i, 1'b0);
            tick();
            checks++;
            if (rob_full_o !== (i == 12)) begin
                failures++;
                $display("FAIL wrap_count[%0d]: got %b expected %b", i, rob_full_o, (i == 12));
            end
        end
        idle();
        checks++; if (rob_tag_o !== 4'd15) begin failures++; $display("FAIL wrap_refill_tag: got %0d expected 15", rob_tag_o); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp[4];
        exp = '{8'h00, pc(1), pc(2), pc(3)};
        do_reset();
        for (int i = 0; i < 10; i++) alloc(1'b1, i + 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            set_wb(k);
            tick();
            checks++;
            if (p_commit_o !== exp[k]) begin
                failures++;
                $display("FAIL midrst_pre[%0d]: got %h expected %h", k, p_commit_o, exp[k]);
            end
        end
        set_wb(4);
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (p_commit_o !== 8'h00) begin failures++; $display("FAIL midrst_p_commit: got %h expected 00", p_commit_o); end
        checks++; if (rob_tag_o !== 4'd0) begin failures++; $display("FAIL midrst_tag: got %0d expected 0", rob_tag_o); end
        checks++; if (rob_full_o !== 1'b0) begin failures++; $display("FAIL midrst_full: got %b expected 0", rob_full_o); end
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL midrst_flush: got %b expected 0", flush_o); end
        idle();
        tick();
        tick();
        rst_ni = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_wb(4 + k);
            tick();
            checks++;
            if (p_commit_o !== 8'h00) begin
                failures++;
                $display("FAIL midrst_post[%0d]: got %h expected 00", k, p_commit_o);
            end
        end
        idle();
        checks++; if (rob_tag_o !== 4'd0) begin failures++; $display("FAIL midrst_post_tag: got %0d expected 0", rob_tag_o); end
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_full();
        test_squash();
        test_hit();
        test_wrap_squash();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
